// File: rtl/sat_counter_bht_pkg.sv
// Shared types and helpers for the saturating-counter branch history table.
// The optional gshare indexing mode is selected by SAT_COUNTER_BHT_GSHARE_EN.
package sat_counter_bht_pkg;

   localparam int MAX_CTR_W = 4;

   typedef enum logic [0:0] {
      READY = 1'b0,
      SWEEP = 1'b1
   } bht_state_e;

   // Weakly not-taken: the value just below the taken threshold.
   function automatic int default_init(input int ctr_w);
      return (1 << (ctr_w - 1)) - 1;
   endfunction

   function automatic logic [MAX_CTR_W-1:0] sat_next(input logic [MAX_CTR_W-1:0] ctr,
                                                     input logic                 taken,
                                                     input int                   ctr_w);
      logic [MAX_CTR_W-1:0] max_v;
      logic [MAX_CTR_W-1:0] res;
      max_v = MAX_CTR_W'((1 << ctr_w) - 1);
      res   = ctr;
      if (taken) begin
         if (ctr != max_v) res = ctr + MAX_CTR_W'(1);
      end else begin
         if (ctr != '0) res = ctr - MAX_CTR_W'(1);
      end
      return res;
   endfunction

endpackage

// File: rtl/sat_counter_bht_if.sv
// Lookup, update and flush signals of the branch history table.
// The history ports exist only when SAT_COUNTER_BHT_GSHARE_EN is defined.
interface sat_counter_bht_if #(
   parameter int PC_W  = 32,
   parameter int IDX_W = 6,
   parameter int CTR_W = 2
);

   logic             lookup_valid;
   logic [PC_W-1:0]  lookup_pc;
   logic             predict_valid;
   logic             predict_taken;
   logic [CTR_W-1:0] predict_ctr;
   logic             update_valid;
   logic [PC_W-1:0]  update_pc;
   logic             update_taken;
   logic             flush;
   logic             busy;
`ifdef SAT_COUNTER_BHT_GSHARE_EN
   logic [IDX_W-1:0] predict_hist;
   logic [IDX_W-1:0] update_hist;
`endif

   modport master (
      output lookup_valid, lookup_pc, update_valid, update_pc, update_taken, flush,
`ifdef SAT_COUNTER_BHT_GSHARE_EN
      output update_hist,
      input  predict_hist,
`endif
      input  predict_valid, predict_taken, predict_ctr, busy
   );

   modport slave (
      input  lookup_valid, lookup_pc, update_valid, update_pc, update_taken, flush,
`ifdef SAT_COUNTER_BHT_GSHARE_EN
      input  update_hist,
      output predict_hist,
`endif
      output predict_valid, predict_taken, predict_ctr, busy
   );

endinterface

// File: rtl/sat_ctr_update.sv
// One saturating counter step; shared by the table write and the lookup bypass.
module sat_ctr_update
   import sat_counter_bht_pkg::*;
#(
   parameter int CTR_W = 2
) (
   input  logic [CTR_W-1:0] ctr_i,
   input  logic             taken_i,
   output logic [CTR_W-1:0] ctr_o
);

   always_comb begin
      ctr_o = CTR_W'(sat_next(MAX_CTR_W'(ctr_i), taken_i, CTR_W));
   end

endmodule

// File: rtl/sat_counter_bht.sv
// Branch history table of 2^IDX_W saturating counters with bypass and flush sweep.
// Define SAT_COUNTER_BHT_GSHARE_EN to XOR a global history register into the index.
module sat_counter_bht
   import sat_counter_bht_pkg::*;
#(
   parameter int PC_W     = 32,
   parameter int IDX_W    = 6,
   parameter int CTR_W    = 2,
   parameter int INIT_VAL = default_init(CTR_W)
) (
   input logic              clk,
   input logic              rst,
   sat_counter_bht_if.slave bus
);

   localparam int               DEPTH    = 1 << IDX_W;
   localparam logic [CTR_W-1:0] INIT_CTR = CTR_W'(INIT_VAL);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   logic [CTR_W-1:0] table_q [DEPTH];
   logic [CTR_W-1:0] table_d [DEPTH];
   bht_state_e       state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic             predict_valid_q, predict_valid_d;
   logic             predict_taken_q, predict_taken_d;
   logic [CTR_W-1:0] predict_ctr_q, predict_ctr_d;

   logic             sweeping;
   logic             update_accept;
   logic [IDX_W-1:0] lookup_idx;
   logic [IDX_W-1:0] update_idx;
   logic [CTR_W-1:0] upd_ctr_cur;
   logic [CTR_W-1:0] upd_ctr_next;
   logic             unused_pc_bits;

`ifdef SAT_COUNTER_BHT_GSHARE_EN
   logic [IDX_W-1:0] ghr_q, ghr_d;
   logic [IDX_W-1:0] predict_hist_q, predict_hist_d;
`endif

   assign unused_pc_bits = ^{bus.lookup_pc, bus.update_pc};

   // Index formation; updates are only accepted outside a sweep and not alongside a flush.
   always_comb begin
      sweeping      = (state_q == SWEEP);
      update_accept = bus.update_valid && !sweeping && !bus.flush;
`ifdef SAT_COUNTER_BHT_GSHARE_EN
      lookup_idx    = bus.lookup_pc[IDX_W+1:2] ^ ghr_q;
      update_idx    = bus.update_pc[IDX_W+1:2] ^ bus.update_hist;
`else
      lookup_idx    = bus.lookup_pc[IDX_W+1:2];
      update_idx    = bus.update_pc[IDX_W+1:2];
`endif
      upd_ctr_cur   = table_q[update_idx];
   end

   sat_ctr_update #(
      .CTR_W(CTR_W)
   ) u_upd (
      .ctr_i  (upd_ctr_cur),
      .taken_i(bus.update_taken),
      .ctr_o  (upd_ctr_next)
   );

   // A flush during a sweep restarts it from entry 0.
   always_comb begin
      table_d = table_q;
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         READY: begin
            if (bus.flush) begin
               state_d = SWEEP;
               ptr_d   = '0;
            end else if (update_accept) begin
               table_d[update_idx] = upd_ctr_next;
            end
         end
         SWEEP: begin
            table_d[ptr_q] = INIT_CTR;
            ptr_d          = ptr_q + IDX_W'(1);
            if (bus.flush) begin
               ptr_d = '0;
            end else if (ptr_q == LAST_IDX) begin
               state_d = READY;
            end
         end
         default: state_d = READY;
      endcase
   end

   // During a sweep the table is reported as already cleared.
   always_comb begin
      predict_valid_d = bus.lookup_valid;
      predict_ctr_d   = predict_ctr_q;
      predict_taken_d = predict_taken_q;
      if (bus.lookup_valid) begin
         if (sweeping) begin
            predict_ctr_d = INIT_CTR;
         end else if (update_accept && (update_idx == lookup_idx)) begin
            predict_ctr_d = upd_ctr_next;
         end else begin
            predict_ctr_d = table_q[lookup_idx];
         end
         predict_taken_d = predict_ctr_d[CTR_W-1];
      end
   end

`ifdef SAT_COUNTER_BHT_GSHARE_EN
   always_comb begin
      ghr_d          = ghr_q;
      predict_hist_d = predict_hist_q;
      if (bus.flush) begin
         ghr_d = '0;
      end else if (update_accept) begin
         ghr_d = (ghr_q << 1) | IDX_W'(bus.update_taken);
      end
      if (bus.lookup_valid) predict_hist_d = ghr_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ghr_q          <= '0;
         predict_hist_q <= '0;
      end else begin
         ghr_q          <= ghr_d;
         predict_hist_q <= predict_hist_d;
      end
   end

   assign bus.predict_hist = predict_hist_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) table_q[i] <= INIT_CTR;
         state_q         <= READY;
         ptr_q           <= '0;
         predict_valid_q <= 1'b0;
         predict_taken_q <= 1'b0;
         predict_ctr_q   <= '0;
      end else begin
         table_q         <= table_d;
         state_q         <= state_d;
         ptr_q           <= ptr_d;
         predict_valid_q <= predict_valid_d;
         predict_taken_q <= predict_taken_d;
         predict_ctr_q   <= predict_ctr_d;
      end
   end

   assign bus.predict_valid = predict_valid_q;
   assign bus.predict_taken = predict_taken_q;
   assign bus.predict_ctr   = predict_ctr_q;
   assign bus.busy          = sweeping;

endmodule

// File: doc/sat_counter_bht.md
Name: sat_counter_bht

Overview:
- Parametrised branch history table: 2^IDX_W independent CTR_W-bit saturating counters, indexed by branch PC.
- Generalises the single 2-bit counter predictor with configurable counter width and table depth, a registered lookup port, a separate update port, same-index bypass and a sequenced flush.
- Sits in the fetch stage; lookups come from fetch, updates come from branch resolution in execute.

Parameters:
- PC_W, 32, PC width; must be >= IDX_W+2.
- IDX_W, 6, index bits; table depth = 2^IDX_W entries.
- CTR_W, 2, counter width; legal range 1..4.
- INIT_VAL, 2^(CTR_W-1)-1, counter value after reset/flush (weakly not-taken).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- lookup_valid  in  1  prediction request
- lookup_pc  in  PC_W  PC of the branch being fetched
- predict_valid  out  1  prediction result valid
- predict_taken  out  1  predicted direction
- predict_ctr  out  CTR_W  raw counter value behind the prediction
- update_valid  in  1  resolved-branch update
- update_pc  in  PC_W  PC of the resolved branch
- update_taken  in  1  actual outcome
- flush  in  1  single-cycle pulse; clears the table
- busy  out  1  flush sweep in progress

Behaviour:
- Index: idx = pc[IDX_W+1:2]. PC bits [1:0] ignored.
- Counter update, applied at the clock edge:
  - taken: ctr+1, saturating at 2^CTR_W-1.
  - not taken: ctr-1, saturating at 0.
  - No wrap in either direction.
- Prediction: predict_taken = ctr[CTR_W-1] (MSB).
- Lookup latency: 1 cycle. predict_* registered; predict_valid = lookup_valid delayed one cycle. predict_taken and predict_ctr hold their last values when predict_valid = 0.
- Bypass: if update_valid and lookup_valid hit the same idx in the same cycle, the prediction reflects the post-update counter value.
- Two updates never collide (one update port).
- Reset: all entries = INIT_VAL; predict_valid = 0, predict_taken = 0, predict_ctr = 0, busy = 0; FSM = READY.
- FSM states:
  - READY: flush -> SWEEP, sweep pointer = 0, busy = 1 from the next cycle.
  - SWEEP: write INIT_VAL to entry[ptr], ptr+1 each cycle. After entry 2^IDX_W-1 is written -> READY. Sweep takes exactly 2^IDX_W cycles.
- During SWEEP:
  - Updates are dropped.
  - Lookups still return predict_valid = 1 with predict_ctr = INIT_VAL, predict_taken = INIT_VAL MSB (the table is treated as already cleared).
- Flush while busy: sweep restarts at ptr = 0.
- Update in the same cycle as flush (READY): dropped.
- rst mid-sweep: sweep aborts; all entries = INIT_VAL, READY, busy = 0.

Optional Feature:
- Macro: SAT_COUNTER_BHT_GSHARE_EN.
- Defined:
  - Adds an IDX_W-bit global history register (GHR), reset to 0.
  - Lookup index = pc[IDX_W+1:2] ^ GHR.
  - Adds output predict_hist [IDX_W-1:0]: the GHR value used for the lookup, registered with predict_*.
  - Adds input update_hist [IDX_W-1:0]: update index = update_pc[IDX_W+1:2] ^ update_hist.
  - GHR shifts left, inserting update_taken at bit 0, on every accepted update; it does not shift on dropped updates.
  - Flush clears the GHR.
- Undefined: plain PC indexing; no GHR, no predict_hist, no update_hist ports.

Decomposition:
- Package sat_counter_bht_pkg: FSM state enum (READY, SWEEP), a saturating next-counter function (ctr, taken, CTR_W), and the default INIT_VAL computation.
- Sub-module sat_ctr_update: combinational saturating increment/decrement of one counter, also used by the bypass path.
- Table array, FSM and GHR stay in the top module.

Test Plan:
- Reset, then lookup PC 0x40 (default params) -> next cycle predict_valid = 1, predict_ctr = 1, predict_taken = 0.
- Three taken updates to PC 0x40, then lookup -> ctr = 3, taken = 1. A fourth taken update leaves ctr = 3 (saturates). Four not-taken updates -> ctr = 0; a fifth leaves 0.
- Same cycle: update taken and lookup, both PC 0x44, ctr = 1 -> predict_ctr = 2, predict_taken = 1 (bypass). Aliasing PC 0x144 (same idx) -> shares the entry.
- Train several entries to 3, pulse flush:
  - busy high for exactly 64 cycles.
  - Updates during the sweep are ignored.
  - Lookups during the sweep return ctr = 1.
  - After the sweep, all entries read 1.
- Flush, then rst at sweep cycle 10 -> busy = 0 immediately; all entries = 1; predict_valid = 0.
- CTR_W = 3, IDX_W = 4: INIT_VAL = 3; saturation at 7 and 0; flush lasts 16 cycles. With GSHARE_EN: the same PC with GHR = 0 vs GHR = 1 maps to distinct entries.
